// File: rtl/urv_irq_ctrl.sv
// Interrupt controller for the uRV core: it synchronises eight raw sources and latches edge or level pending bits.
// A round-robin arbiter then raises a single one-hot request and tracks it through claim and done.
module urv_irq_ctrl (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] irq_i,
    input  logic       cfg_we_i,
    input  logic [1:0] cfg_addr_i,
    input  logic [7:0] cfg_wdata_i,
    output logic [7:0] cfg_rdata_o,
    output logic [7:0] irq_o,
    input  logic       claim_i,
    input  logic       done_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIGNAL  = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [7:0] sync_q1, sync_q2, sync_q3;
    logic [7:0] enable_q, edge_q;
    logic [7:0] pend_q, pend_d;
    state_e     state_q, state_d;
    logic [2:0] id_q, id_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] irq_q, irq_d;
    logic       busy_q, busy_d;

    logic [7:0] edge_det_s;
    logic [7:0] clr_s;
    logic [7:0] claim_clr_s;
    logic [3:0] pick_s;

    // Round-robin search from ptr+1 upward; result is {found, index}.
    // The loop runs from the farthest candidate to the nearest so that the nearest match wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'd1 + 3'(k);
            res = req[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Two-flop synchroniser plus a third stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q1 <= 8'h00;
            sync_q2 <= 8'h00;
            sync_q3 <= 8'h00;
        end else begin
            sync_q1 <= irq_i;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    // Configuration registers; the EDGE register resets to all sources in edge mode.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable_q <= 8'h00;
            edge_q   <= 8'hFF;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                ADDR_ENABLE: enable_q <= cfg_wdata_i;
                ADDR_EDGE:   edge_q   <= cfg_wdata_i;
                default:     ;
            endcase
        end
    end

    // Pending bits: edge-mode bits are sticky, with a set taking priority over a clear.
    // Level-mode bits follow the synchronised input.
    always_comb begin
        edge_det_s  = sync_q2 & ~sync_q3;
        clr_s       = 8'h00;
        claim_clr_s = 8'h00;
        if (cfg_we_i && (cfg_addr_i == ADDR_PENDING)) begin
            clr_s = cfg_wdata_i;
        end else begin
            clr_s = 8'h00;
        end
        if ((state_q == ST_SIGNAL) && claim_i) begin
            claim_clr_s = 8'h01 << id_q;
        end else begin
            claim_clr_s = 8'h00;
        end
        pend_d = (edge_q & (edge_det_s | (pend_q & ~(clr_s | claim_clr_s))))
               | (~edge_q & sync_q2);
    end

    // Arbitration FSM: the next state and the registered request/busy values.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        irq_d    = 8'h00;
        pick_s   = rr_pick(pend_q & enable_q, rr_ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    state_d = ST_SIGNAL;
                    id_d    = pick_s[2:0];
                    irq_d   = 8'h01 << pick_s[2:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SIGNAL: begin
                if (claim_i) begin
                    state_d = ST_SERVICE;
                end else if (!enable_q[id_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SIGNAL;
                    irq_d   = 8'h01 << id_q;
                end
            end
            ST_SERVICE: begin
                if (done_i) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = id_q;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Pending, FSM and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q   <= 8'h00;
            state_q  <= ST_IDLE;
            id_q     <= 3'd0;
            rr_ptr_q <= 3'd7;
            irq_q    <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
        end
    end

    // Combinational register read-back.
    always_comb begin
        cfg_rdata_o = 8'h00;
        case (cfg_addr_i)
            ADDR_ENABLE:  cfg_rdata_o = enable_q;
            ADDR_EDGE:    cfg_rdata_o = edge_q;
            ADDR_PENDING: cfg_rdata_o = pend_q;
            ADDR_STATUS:  cfg_rdata_o = {busy_q, (state_q == ST_SERVICE), 3'b000, id_q};
            default:      cfg_rdata_o = 8'h00;
        endcase
    end

    assign irq_o  = irq_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Self-checking bench for urv_irq_ctrl. Expected grants are queued when a source is stimulated
// and matched by a monitor whenever irq_o rises.
module tb_urv_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic [7:0] irq_i = 8'h00;
    logic       cfg_we_i = 1'b0;
    logic [1:0] cfg_addr_i = 2'd0;
    logic [7:0] cfg_wdata_i = 8'h00;
    logic [7:0] cfg_rdata_o;
    logic [7:0] irq_o;
    logic       claim_i = 1'b0;
    logic       done_i = 1'b0;
    logic       busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] prev_irq = 8'h00;
    logic [7:0] exp_grant;

    urv_irq_ctrl dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .irq_i       (irq_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .irq_o       (irq_o),
        .claim_i     (claim_i),
        .done_i      (done_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        tick(1);
        cfg_we_i    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp_v);
        cfg_addr_i = a;
        #1;
        check_eq(tag, cfg_rdata_o, exp_v);
    endtask

    task automatic pulse_claim();
        claim_i = 1'b1;
        tick(1);
        claim_i = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        tick(1);
    endtask

    // Scoreboard monitor: each new request must match the oldest queued grant.
    always @(negedge clk_i) begin
        if (rst_n_i && (irq_o != 8'h00) && (prev_irq == 8'h00)) begin
            if (sb_q.size() > 0) begin
                exp_grant = sb_q.pop_front();
                check_eq("grant", irq_o, exp_grant);
            end else begin
                check_eq("grant_unexpected", irq_o, 8'h00);
            end
        end
        prev_irq = irq_o;
    end

    initial begin
        #1 rst_n_i = 1'b0;
        #1;
        check_eq("rst_irq", irq_o, 8'h00);
        check_eq("rst_busy", {7'd0, busy_o}, 8'h00);
        read_check("rst_enable", 2'd0, 8'h00);
        read_check("rst_edge", 2'd1, 8'hFF);
        tick(1);
        read_check("rst_pending", 2'd2, 8'h00);
        read_check("rst_status", 2'd3, 8'h00);
        tick(1);
        rst_n_i = 1'b1;
        tick(1);

        // Single edge source: latency, claim and done.
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd1, 8'h01);
        sb_q.push_back(8'h01);
        irq_i = 8'h01;
        tick(2);
        irq_i = 8'h00;
        tick(1);
        check_eq("t1_not_early", irq_o, 8'h00);
        tick(1);
        check_eq("t1_irq", irq_o, 8'h01);
        check_eq("t1_busy", {7'd0, busy_o}, 8'h01);
        pulse_claim();
        check_eq("t1_irq_claimed", irq_o, 8'h00);
        read_check("t1_pending", 2'd2, 8'h00);
        read_check("t1_status", 2'd3, 8'hC0);
        pulse_done();
        check_eq("t1_busy_done", {7'd0, busy_o}, 8'h00);

        // Two simultaneous edges: round-robin from reset picks 0, then 7.
        do_reset();
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd1, 8'hFF);
        sb_q.push_back(8'h01);
        sb_q.push_back(8'h80);
        irq_i = 8'h81;
        tick(2);
        irq_i = 8'h00;
        tick(2);
        check_eq("t2_first", irq_o, 8'h01);
        pulse_claim();
        pulse_done();
        check_eq("t2_idle_gap", irq_o, 8'h00);
        tick(1);
        check_eq("t2_second", irq_o, 8'h80);
        pulse_claim();
        read_check("t2_status", 2'd3, 8'hC7);
        pulse_done();
        check_eq("t2_busy_done", {7'd0, busy_o}, 8'h00);

        // Level source 3: re-signals while held, not after release.
        cfg_write(2'd1, 8'h00);
        cfg_write(2'd0, 8'h08);
        sb_q.push_back(8'h08);
        irq_i = 8'h08;
        tick(3);
        check_eq("t3_not_early", irq_o, 8'h00);
        tick(1);
        check_eq("t3_irq", irq_o, 8'h08);
        pulse_claim();
        check_eq("t3_irq_claimed", irq_o, 8'h00);
        read_check("t3_pend_level", 2'd2, 8'h08);
        pulse_done();
        check_eq("t3_idle_gap", irq_o, 8'h00);
        sb_q.push_back(8'h08);
        tick(1);
        check_eq("t3_resignal", irq_o, 8'h08);
        pulse_claim();
        irq_i = 8'h00;
        tick(3);
        read_check("t3_pend_drop", 2'd2, 8'h00);
        pulse_done();
        tick(3);
        check_eq("t3_no_resignal", irq_o, 8'h00);
        check_eq("t3_busy", {7'd0, busy_o}, 8'h00);

        // Disable while signalling: abandon the request, keep it pending, re-signal on enable.
        do_reset();
        cfg_write(2'd0, 8'h04);
        sb_q.push_back(8'h04);
        irq_i = 8'h04;
        tick(2);
        irq_i = 8'h00;
        tick(2);
        check_eq("t4_irq", irq_o, 8'h04);
        cfg_write(2'd0, 8'h00);
        tick(1);
        check_eq("t4_dropped", irq_o, 8'h00);
        check_eq("t4_busy", {7'd0, busy_o}, 8'h00);
        read_check("t4_pending", 2'd2, 8'h04);
        sb_q.push_back(8'h04);
        cfg_write(2'd0, 8'h04);
        tick(1);
        check_eq("t4_resignal", irq_o, 8'h04);
        pulse_claim();
        read_check("t4_pend_clr", 2'd2, 8'h00);
        pulse_done();

        // An edge coincident with a PENDING clear write leaves the bit set; a disabled source still latches.
        cfg_write(2'd0, 8'h00);
        irq_i = 8'h20;
        tick(2);
        cfg_write(2'd2, 8'h20);
        irq_i = 8'h00;
        read_check("t5_set_wins", 2'd2, 8'h20);
        tick(3);
        cfg_write(2'd2, 8'h20);
        read_check("t5_cleared", 2'd2, 8'h00);

        // Asynchronous reset during SERVICE.
        cfg_write(2'd0, 8'h02);
        sb_q.push_back(8'h02);
        irq_i = 8'h02;
        tick(2);
        irq_i = 8'h00;
        tick(2);
        check_eq("t6_irq", irq_o, 8'h02);
        pulse_claim();
        check_eq("t6_busy_service", {7'd0, busy_o}, 8'h01);
        #1 rst_n_i = 1'b0;
        #1;
        check_eq("t6_rst_irq", irq_o, 8'h00);
        check_eq("t6_rst_busy", {7'd0, busy_o}, 8'h00);
        read_check("t6_rst_edge", 2'd1, 8'hFF);
        tick(2);
        rst_n_i = 1'b1;
        tick(2);

        check_eq("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
